irom_loader: RTL

//  Byte-stream programmer that fills the instruction RAM from an external byte source (UART RX / debug link).
//  It is the write side of the instruction memory: the core only reads it; this block writes it.

---
 rtl/irom_loader_pkg.sv | 19 +
 rtl/irom_word_packer.sv | 32 +++
 rtl/irom_loader.sv | 189 ++++++++++++++++++
 3 files changed

// File: rtl/irom_loader_pkg.sv
// Shared types and constants for the instruction-RAM byte-stream loader.
package irom_loader_pkg;

  localparam int unsigned ADDR_W_DEFAULT = 14;
  localparam int unsigned IRAM_DEPTH     = 2 ** ADDR_W_DEFAULT;
  localparam int unsigned BYTE_W         = 8;
  localparam int unsigned LEN_BYTES      = 2;
  localparam int unsigned WORD_BYTES     = 4;
  localparam int unsigned LEN_W          = LEN_BYTES * BYTE_W;
  localparam int unsigned WORD_IDX_W     = $clog2(WORD_BYTES);

  typedef enum logic [1:0] {
    IDLE,
    LEN,
    DATA,
    CSUM
  } loader_state_e;

endpackage

// File: rtl/irom_word_packer.sv
// Assembles little-endian bytes into IRAM words; word_valid/word form the registered write payload.
module irom_word_packer
  import irom_loader_pkg::*;
#(
  parameter int unsigned DATA_W = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  clear,
  input  logic                  byte_valid,
  input  logic [BYTE_W-1:0]     byte_data,
  output logic [WORD_IDX_W-1:0] byte_idx,
  output logic                  word_valid,
  output logic [DATA_W-1:0]     word
);

  // Shift in from the top so the first byte of a word ends up in bits 7:0.
  always_ff @(posedge clk) begin
    if (rst || clear) begin
      byte_idx   <= '0;
      word_valid <= 1'b0;
      word       <= '0;
    end else begin
      word_valid <= byte_valid && (byte_idx == WORD_IDX_W'(WORD_BYTES - 1));
      if (byte_valid) begin
        word     <= {byte_data, word[DATA_W-1:BYTE_W]};
        byte_idx <= byte_idx + WORD_IDX_W'(1);
      end
    end
  end

endmodule

// File: rtl/irom_loader.sv
// Byte-stream IRAM programmer: length header, little-endian words, optional checksum byte.
// Build option: define IROM_LOADER_CHECKSUM_EN to require a trailing mod-256 sum of the data bytes.
module irom_loader
  import irom_loader_pkg::*;
#(
  parameter int unsigned ADDR_W      = ADDR_W_DEFAULT,
  parameter int unsigned DATA_W      = 32,
  parameter int unsigned TIMEOUT_CYC = 1_000_000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load_start,
  input  logic [BYTE_W-1:0] rx_data,
  input  logic              rx_valid,
  output logic              rx_ready,
  output logic              iram_we,
  output logic [ADDR_W-1:0] iram_addr,
  output logic [DATA_W-1:0] iram_wdata,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic              cpu_hold
);

  localparam int unsigned TO_W  = $clog2(TIMEOUT_CYC + 1);
  localparam int unsigned DEPTH = 2 ** ADDR_W;

  loader_state_e         state, state_nx;
  logic [BYTE_W-1:0]     len_lo, len_lo_nx;
  logic                  len_phase, len_phase_nx;
  logic [LEN_W-1:0]      words_left, words_left_nx;
  logic [TO_W-1:0]       idle_cnt, idle_cnt_nx;
  logic [ADDR_W-1:0]     addr_nx;
  logic                  done_nx, err_nx;
  logic [LEN_W-1:0]      len_n_c;
  logic [WORD_IDX_W-1:0] byte_idx;
  logic                  xfer_c, start_c, timeout_c, pack_valid_c, pack_clear_c;
`ifdef IROM_LOADER_CHECKSUM_EN
  logic [BYTE_W-1:0]     csum, csum_nx;
`endif

  assign rx_ready     = (state != IDLE);
  assign busy         = (state != IDLE);
  assign cpu_hold     = busy;
  assign xfer_c       = rx_valid && rx_ready;
  assign start_c      = (state == IDLE) && load_start;
  assign timeout_c    = busy && !xfer_c && (idle_cnt == TO_W'(TIMEOUT_CYC - 1));
  assign pack_valid_c = (state == DATA) && xfer_c;
  assign pack_clear_c = start_c || timeout_c;
  assign len_n_c      = {rx_data, len_lo};

  irom_word_packer #(
    .DATA_W (DATA_W)
  ) u_packer (
    .clk        (clk),
    .rst        (rst),
    .clear      (pack_clear_c),
    .byte_valid (pack_valid_c),
    .byte_data  (rx_data),
    .byte_idx   (byte_idx),
    .word_valid (iram_we),
    .word       (iram_wdata)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      len_lo     <= '0;
      len_phase  <= 1'b0;
      words_left <= '0;
      idle_cnt   <= '0;
      iram_addr  <= '0;
      done       <= 1'b0;
      err        <= 1'b0;
`ifdef IROM_LOADER_CHECKSUM_EN
      csum       <= '0;
`endif
    end else begin
      state      <= state_nx;
      len_lo     <= len_lo_nx;
      len_phase  <= len_phase_nx;
      words_left <= words_left_nx;
      idle_cnt   <= idle_cnt_nx;
      iram_addr  <= addr_nx;
      done       <= done_nx;
      err        <= err_nx;
`ifdef IROM_LOADER_CHECKSUM_EN
      csum       <= csum_nx;
`endif
    end
  end

  // Next-state and bookkeeping; the last data byte moves the FSM on while its write is still in flight.
  always_comb begin
    state_nx      = state;
    len_lo_nx     = len_lo;
    len_phase_nx  = len_phase;
    words_left_nx = words_left;
    idle_cnt_nx   = idle_cnt;
    addr_nx       = iram_addr;
    done_nx       = done;
    err_nx        = err;
`ifdef IROM_LOADER_CHECKSUM_EN
    csum_nx       = csum;
`endif

    if (busy) begin
      idle_cnt_nx = xfer_c ? '0 : idle_cnt + TO_W'(1);
    end
    // Saturate at the top word so a full-depth image never wraps onto address 0.
    if (iram_we && (iram_addr != '1)) begin
      addr_nx = iram_addr + ADDR_W'(1);
    end

    case (state)
      IDLE: begin
        if (load_start) begin
          state_nx      = LEN;
          done_nx       = 1'b0;
          err_nx        = 1'b0;
          addr_nx       = '0;
          len_phase_nx  = 1'b0;
          idle_cnt_nx   = '0;
          words_left_nx = '0;
`ifdef IROM_LOADER_CHECKSUM_EN
          csum_nx       = '0;
`endif
        end
      end
      LEN: begin
        if (xfer_c) begin
          if (!len_phase) begin
            len_lo_nx    = rx_data;
            len_phase_nx = 1'b1;
          end else begin
            words_left_nx = len_n_c;
            if (len_n_c == '0) begin
              done_nx  = 1'b1;
              state_nx = IDLE;
            end else if (32'(len_n_c) > DEPTH) begin
              err_nx   = 1'b1;
              state_nx = IDLE;
            end else begin
              state_nx = DATA;
            end
          end
        end
      end
      DATA: begin
        if (xfer_c) begin
`ifdef IROM_LOADER_CHECKSUM_EN
          csum_nx = csum + rx_data;
`endif
          if (byte_idx == WORD_IDX_W'(WORD_BYTES - 1)) begin
            words_left_nx = words_left - LEN_W'(1);
            if (words_left == LEN_W'(1)) begin
`ifdef IROM_LOADER_CHECKSUM_EN
              state_nx = CSUM;
`else
              done_nx  = 1'b1;
              state_nx = IDLE;
`endif
            end
          end
        end
      end
`ifdef IROM_LOADER_CHECKSUM_EN
      CSUM: begin
        if (xfer_c) begin
          if (rx_data == csum) begin
            done_nx = 1'b1;
          end else begin
            err_nx  = 1'b1;
          end
          state_nx = IDLE;
        end
      end
`endif
      default: state_nx = IDLE;
    endcase

    if (timeout_c) begin
      err_nx   = 1'b1;
      done_nx  = 1'b0;
      state_nx = IDLE;
    end
  end

endmodule
